// File: rtl/simple_spi_master.sv
// SPI mode-0 initiator: 8-bit command then 32-bit word, MSB first, one transaction per start.
// MISO is double-synchronised and sampled at the end of each SCK high phase.
module simple_spi_master #(
   parameter int CLK_DIV  = 4,
   parameter int CS_SETUP = 2,
   parameter int CS_HOLD  = 2,
   parameter int CS_IDLE  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  command,
   input  logic [31:0] word_out,
   output logic        busy,
   output logic        done,
   output logic [31:0] word_in,
   output logic        sck,
   output logic        mosi,
   input  logic        miso,
   output logic        cs
);
   // state    | meaning
   // S_IDLE   | cs high, waiting for start
   // S_SETUP  | cs low, first MOSI bit presented before SCK runs
   // S_SCK_LO | SCK low half-period
   // S_SCK_HI | SCK high half-period; MISO sampled and MOSI advanced on its last cycle
   // S_HOLD   | cs still low after the last SCK fall
   // S_GAP    | cs high before busy drops
   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SCK_LO, S_SCK_HI, S_HOLD, S_GAP} state_t;

   localparam int CW = 16;
   // SETUP holds one extra cycle so accept->done totals 1 + CS_SETUP + 80*CLK_DIV + CS_HOLD + CS_IDLE
   localparam logic [CW-1:0] LD_SETUP = CW'(CS_SETUP);
   localparam logic [CW-1:0] LD_DIV   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] LD_HOLD  = CW'(CS_HOLD - 1);
   localparam logic [CW-1:0] LD_IDLE  = CW'(CS_IDLE - 1);

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [5:0]    r_bit, w_bit_nxt;
   logic [39:0]   r_shift, w_shift_nxt;
   logic [31:0]   r_cap, w_cap_nxt;
   logic [31:0]   r_word_in, w_word_in_nxt;
   logic          r_busy, w_busy_nxt;
   logic          r_done, w_done_nxt;
   logic          r_sck, w_sck_nxt;
   logic          r_cs, w_cs_nxt;
   logic          r_miso_s1, r_miso_s2;
   logic          w_tc;

   assign w_tc = (r_cnt == '0);

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_bit_nxt     = r_bit;
      w_shift_nxt   = r_shift;
      w_cap_nxt     = r_cap;
      w_word_in_nxt = r_word_in;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_sck_nxt     = r_sck;
      w_cs_nxt      = r_cs;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt = S_SETUP;
               w_cnt_nxt   = LD_SETUP;
               w_bit_nxt   = 6'd39;
               w_shift_nxt = {command, word_out};
               w_cap_nxt   = '0;
               w_busy_nxt  = 1'b1;
               w_cs_nxt    = 1'b0;
            end
         end
         S_SETUP: begin
            if (w_tc) begin
               w_state_nxt = S_SCK_LO;
               w_cnt_nxt   = LD_DIV;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         S_SCK_LO: begin
            if (w_tc) begin
               w_state_nxt = S_SCK_HI;
               w_cnt_nxt   = LD_DIV;
               w_sck_nxt   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         S_SCK_HI: begin
            if (w_tc) begin
               w_sck_nxt   = 1'b0;
               w_shift_nxt = {r_shift[38:0], 1'b0};
               if (r_bit < 6'd32) begin
                  w_cap_nxt = {r_cap[30:0], r_miso_s2};
               end
               if (r_bit == 6'd0) begin
                  w_state_nxt = S_HOLD;
                  w_cnt_nxt   = LD_HOLD;
               end else begin
                  w_state_nxt = S_SCK_LO;
                  w_cnt_nxt   = LD_DIV;
                  w_bit_nxt   = r_bit - 6'd1;
               end
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         S_HOLD: begin
            if (w_tc) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = LD_IDLE;
               w_cs_nxt    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         S_GAP: begin
            if (w_tc) begin
               w_state_nxt   = S_IDLE;
               w_busy_nxt    = 1'b0;
               w_done_nxt    = 1'b1;
               w_word_in_nxt = r_cap;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_cap     <= '0;
         r_word_in <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_sck     <= 1'b0;
         r_cs      <= 1'b1;
         r_miso_s1 <= 1'b0;
         r_miso_s2 <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit     <= w_bit_nxt;
         r_shift   <= w_shift_nxt;
         r_cap     <= w_cap_nxt;
         r_word_in <= w_word_in_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_sck     <= w_sck_nxt;
         r_cs      <= w_cs_nxt;
         r_miso_s1 <= miso;
         r_miso_s2 <= r_miso_s1;
      end
   end

   // shift register drains to zero, so MOSI is low again by HOLD/GAP
   assign mosi    = r_shift[39];
   assign busy    = r_busy;
   assign done    = r_done;
   assign word_in = r_word_in;
   assign sck     = r_sck;
   assign cs      = r_cs;
endmodule
